alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one 32-bit combinational ALU between N requesters using round-robin arbitration and valid/ready handshakes.
// - Drives the ALU operand and control inputs from the granted requester and registers the ALU result into a 1-entry response buffer.
// - Sits between the execute-stage issue logic (and any address or auxiliary units) and the shared ALU.
// PARAMETERS
// - N_REQ   default 4   number of requesters, 2..8
// - ID_W    default 2   width of the requester index, = $clog2(N_REQ)
// PORTS
// - clk           in   1         system clock, rising edge
// - rst           in   1         asynchronous reset, active low
// - req_valid     in   N_REQ     per-requester operation valid
// - req_ready     out  N_REQ     per-requester accept; a transfer happens when valid and ready are both high
// - req_ctrl      in   4*N_REQ   per-requester ALU control code; requester i uses bits [4i+3:4i]
// - req_a         in   32*N_REQ  per-requester operand A; requester i uses bits [32i+31:32i]
// - req_b         in   32*N_REQ  per-requester operand B, same slicing as req_a
// - alu_ctrl      out  4         control code to the shared ALU
// - alu_a         out  32        operand A to the shared ALU
// - alu_b         out  32        operand B to the shared ALU
// - alu_result    in   32        combinational result from the shared ALU
// - rsp_valid     out  1         response buffer holds a result
// - rsp_ready     in   1         consumer accepts the response
// - rsp_result    out  32        registered ALU result
// - rsp_id        out  ID_W      index of the requester that owns rsp_result
// - perf_grant_cnt out 16*N_REQ  per-requester grant counters; present only with ALU_ARB_PERF_EN
// BEHAVIOUR
// - Reset (rst low, asynchronous): rsp_valid=0, rsp_result=0, rsp_id=0, round-robin pointer=0, perf counters=0.
//   - While rst is low, req_ready is all zeros.
//   - If reset is asserted mid-operation, any held response is discarded.
// - can_accept = !rsp_valid | rsp_ready. A drain and a new accept may occur in the same cycle.
// - Grant selection is round-robin:
//   - Search starts at the pointer and wraps modulo N_REQ; the first requester with valid high wins.
//   - The pointer then moves to (winner+1) mod N_REQ, but only on an accepted transfer.
// - req_ready[i] = grant[i] & can_accept. It is combinational and one-hot or all zeros, with no dependence on req_ready itself.
// - ALU drive: alu_ctrl, alu_a and alu_b carry the granted requester's fields whenever any request is valid.
//   - With no request valid: alu_ctrl=4'b0000, alu_a=0, alu_b=0.
// - On an accepted transfer at edge T:
//   - rsp_result <= alu_result, rsp_id <= winner, rsp_valid <= 1.
//   - Latency is 1 cycle. Throughput is 1 op/cycle while rsp_ready stays high.
// - If rsp_valid & rsp_ready and there is no new accept: rsp_valid <= 0. rsp_result and rsp_id hold their last value.
// - While rsp_valid & !rsp_ready: rsp_result, rsp_id and rsp_valid stay stable, and all req_ready are 0.
// - Requester rule: once req_valid is high, the requester holds it and its fields stable until req_ready is seen. The block does not check this.
// - Control codes 4'b1010..4'b1111 pass through unchanged; the ALU returns 0 for them and the arbiter does not flag them.
// - Requesters are independent: at most one transfer per cycle in total, and no requester is starved for more than N_REQ-1 grants.
// CONFIGURATION
// - ALU_ARB_PERF_EN defined:
//   - One 16-bit counter per requester increments on each accepted transfer from that requester.
//   - Each counter saturates at 16'hFFFF and is exposed on perf_grant_cnt.
// - ALU_ARB_PERF_EN undefined: the counters and the perf_grant_cnt port do not exist. All other behaviour is identical.
// STRUCTURE
// - Package alu_arb_pkg holds:
//   - ALU control encodings ALU_ADD=0, ALU_SUB=1, ALU_SLL=2, ALU_SLT=3, ALU_SLTU=4, ALU_XOR=5, ALU_SRL=6, ALU_SRA=7, ALU_OR=8, ALU_AND=9.
//   - ALU_CTRL_W=4 and XLEN=32.
// - Sub-module alu_rr_arbiter (N_REQ): inputs req vector, pointer and advance; outputs one-hot grant and winner index. The pointer register lives inside it.
// - The top level holds the operand mux, the response buffer and the optional counters. The ALU is instantiated outside this block.
// TESTING (bench instantiates the shared ALU and connects it to the alu_* ports; N_REQ=4)
// - Single request: req0 ADD, a=5, b=7, rsp_ready=1 -> req_ready[0]=1 in the same cycle; next cycle rsp_valid=1, rsp_result=12, rsp_id=0.
// - Fairness: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,... with one response per cycle and no gaps.
// - Backpressure: rsp_valid=1 with rsp_ready=0 for 5 cycles -> req_ready=0000 and rsp_result/rsp_id stable.
//   - Then raise rsp_ready -> drain and new accept in the same cycle, with rsp_valid staying 1.
// - Arithmetic pass-through: SUB a=3 b=5 -> 32'hFFFFFFFE; SLL a=1 b=32'h23 -> 32'h8; ctrl 4'b1111 -> 0.
// - Reset mid-operation: drive rst low while rsp_valid=1 -> rsp_valid=0 immediately (asynchronous).
//   - After release, with req1 and req3 valid -> req1 is granted first, since the pointer is back at 0.
// - Perf counters: with ALU_ARB_PERF_EN, 3 accepted requests on req2 -> perf_grant_cnt[47:32]=3 and all others 0.
//   - Without the macro, the build has no perf_grant_cnt port.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU share arbiter: control encodings,
// datapath widths and the operand payload carried to the shared ALU.
package alu_arb_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
  } alu_op_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, shared-ALU and response signals of the ALU share arbiter.
// slave = arbiter side, master = requester/ALU/consumer side.
interface alu_share_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [ALU_CTRL_W*N_REQ-1:0] req_ctrl;
  logic [XLEN*N_REQ-1:0]       req_a;
  logic [XLEN*N_REQ-1:0]       req_b;
  logic [ALU_CTRL_W-1:0]       alu_ctrl;
  logic [XLEN-1:0]             alu_a;
  logic [XLEN-1:0]             alu_b;
  logic [XLEN-1:0]             alu_result;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [XLEN-1:0]             rsp_result;
  logic [ID_W-1:0]             rsp_id;

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_result, rsp_id
  );

  modport master (
    output req_valid, req_ctrl, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_result, rsp_id
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer and wraps; the pointer
// moves past the winner only when the grant is actually taken (advance).
module alu_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  winner
);
  localparam int unsigned SUM_W = ID_W + 1;

  logic [ID_W-1:0] ptr;

  // First valid requester at or after ptr, modulo N_REQ
  always_comb begin
    logic             found;
    logic [SUM_W-1:0] pos;
    logic [ID_W-1:0]  idx;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = SUM_W'(ptr) + SUM_W'(k);
      if (pos >= SUM_W'(N_REQ)) pos = pos - SUM_W'(N_REQ);
      idx = pos[ID_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among N_REQ requesters with a 1-entry response
// buffer. Optional per-requester grant counters: ALU_ARB_PERF_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_share_arbiter_if.slave     bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [16*N_REQ-1:0]    perf_grant_cnt
`endif
);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  winner;
  logic             can_accept;
  logic             accept;
  alu_op_t          ops [N_REQ];
  alu_op_t          sel_op;

  assign can_accept    = !bus.rsp_valid || bus.rsp_ready;
  assign bus.req_ready = rst ? (grant & {N_REQ{can_accept}}) : '0;
  assign accept        = |bus.req_ready;

  alu_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant),
    .winner  (winner)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_ops
    assign ops[g] = {bus.req_ctrl[ALU_CTRL_W*g +: ALU_CTRL_W],
                     bus.req_a[XLEN*g +: XLEN],
                     bus.req_b[XLEN*g +: XLEN]};
  end

  // ALU sees zeros when nobody is requesting
  assign sel_op       = (|grant) ? ops[winner] : '0;
  assign bus.alu_ctrl = sel_op.ctrl;
  assign bus.alu_a    = sel_op.a;
  assign bus.alu_b    = sel_op.b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_id     <= '0;
    end else if (accept) begin
      bus.rsp_valid  <= 1'b1;
      bus.rsp_result <= bus.alu_result;
      bus.rsp_id     <= winner;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    logic [15:0] cnt;
    // Saturating count of accepted transfers from requester g
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (accept && grant[g] && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign perf_grant_cnt[16*g +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter (N_REQ=4) with the
// shared ALU modelled here; build with ALU_ARB_PERF_EN to cover the counters.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst;

  alu_share_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic [16*N-1:0] perf;
`endif

  alu_share_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Requester-side stimulus state
  logic [3:0]  v;
  logic [3:0]  c [N];
  logic [31:0] a [N];
  logic [31:0] b [N];
  logic        rr;

  // Reference model state
  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_res;
  logic [1:0]  m_id;
  int          m_cnt [N];
  int          last_acc;

  logic [3:0]  exp_ready, obs_ready, exp_ctrl, obs_ctrl;
  logic [31:0] exp_a, obs_a, exp_b, obs_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    case (op)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x - y;
      ALU_SLL:  return x << y[4:0];
      ALU_SLT:  return {31'd0, $signed(x) < $signed(y)};
      ALU_SLTU: return {31'd0, x < y};
      ALU_XOR:  return x ^ y;
      ALU_SRL:  return x >> y[4:0];
      ALU_SRA:  return 32'($signed(x) >>> y[4:0]);
      ALU_OR:   return x | y;
      ALU_AND:  return x & y;
      default:  return 32'd0;
    endcase
  endfunction

  // The shared ALU lives outside the arbiter
  always_comb bus.alu_result = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  task automatic new_op(input int i);
    c[2'(i)] = 4'($urandom_range(0, 15));
    a[2'(i)] = $urandom;
    b[2'(i)] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
  endtask

  task automatic apply();
    bus.req_valid = v;
    bus.rsp_ready = rr;
    bus.req_ctrl  = {c[3], c[2], c[1], c[0]};
    bus.req_a     = {a[3], a[2], a[1], a[0]};
    bus.req_b     = {b[3], b[2], b[1], b[0]};
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_valid  = 1'b0;
    m_res    = '0;
    m_id     = '0;
    last_acc = -1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock: drive at posedge+1, observe at negedge, advance model at posedge
  task automatic cycle();
    int win;
    win = -1;
    apply();
    @(negedge clk);
    for (int k = 0; k < N; k++)
      if (win < 0 && v[2'((m_ptr + k) % N)]) win = (m_ptr + k) % N;
    exp_ready = (win >= 0 && (!m_valid || rr)) ? 4'(1 << win) : 4'b0000;
    exp_ctrl  = (win >= 0) ? c[2'(win)] : 4'd0;
    exp_a     = (win >= 0) ? a[2'(win)] : 32'd0;
    exp_b     = (win >= 0) ? b[2'(win)] : 32'd0;
    obs_ready = bus.req_ready;
    obs_ctrl  = bus.alu_ctrl;
    obs_a     = bus.alu_a;
    obs_b     = bus.alu_b;
    @(posedge clk);
    last_acc = -1;
    if (exp_ready != 4'b0000) begin
      m_res   = alu_ref(c[2'(win)], a[2'(win)], b[2'(win)]);
      m_id    = 2'(win);
      m_valid = 1'b1;
      m_ptr   = (win + 1) % N;
      if (m_cnt[win] < 65535) m_cnt[win]++;
      last_acc = win;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Retire the accepted request; idle requesters start a new op with pct% chance
  task automatic refill(input int pct);
    if (last_acc >= 0) v[2'(last_acc)] = 1'b0;
    for (int i = 0; i < N; i++)
      if (!v[2'(i)] && $urandom_range(0, 99) < pct) begin
        v[2'(i)] = 1'b1;
        new_op(i);
      end
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && v != 4'b0000; k++) begin
      rr = 1'b1;
      cycle();
      refill(0);
    end
    rr = 1'b1;
    cycle();
    checks++;
    if (v !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%b rsp_valid=%b, expected 0000/0", v, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rr  = 1'b1;
    v   = 4'b1111;
    for (int i = 0; i < N; i++) new_op(i);
    model_reset();
    apply();
    #3;
    checks += 4;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rsp_valid); end
    if (bus.rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.rsp_result); end
    if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", bus.rsp_id); end
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    v   = 4'b0000;
    apply();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    v = 4'b0001; c[0] = ALU_ADD; a[0] = 32'd5; b[0] = 32'd7; rr = 1'b1;
    cycle();
    v = 4'b0000;
    checks += 5;
    if (obs_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", obs_ready); end
    if (obs_a !== 32'd5) begin errors++; $display("FAIL single_alu_a: got %h expected 5", obs_a); end
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.rsp_valid); end
    if (bus.rsp_result !== 32'd12) begin errors++; $display("FAIL single_result: got %0d expected 12", bus.rsp_result); end
    if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", bus.rsp_id); end
    cycle();
    checks += 3;
    if (obs_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b expected 0000", obs_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_drain: got %b expected 0", bus.rsp_valid); end
    if (bus.rsp_result !== 32'd12) begin errors++; $display("FAIL idle_hold: got %0d expected 12", bus.rsp_result); end
  endtask

  task automatic test_fairness();
    int prev;
    v  = 4'b1111;
    rr = 1'b1;
    for (int i = 0; i < N; i++) new_op(i);
    prev = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      checks += 4;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", k, obs_ready, exp_ready); end
      if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL fair_valid[%0d]: got %b expected 1", k, bus.rsp_valid); end
      if (bus.rsp_result !== m_res) begin errors++; $display("FAIL fair_result[%0d]: got %h expected %h", k, bus.rsp_result, m_res); end
      if (prev >= 0 && bus.rsp_id !== 2'((prev + 1) % N)) begin
        errors++; $display("FAIL fair_id[%0d]: got %0d expected %0d", k, bus.rsp_id, (prev + 1) % N);
      end
      prev = int'(bus.rsp_id);
      refill(100);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_res;
    logic [1:0]  held_id;
    held_res = bus.rsp_result;
    held_id  = bus.rsp_id;
    rr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks += 4;
      if (obs_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, obs_ready); end
      if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, bus.rsp_valid); end
      if (bus.rsp_result !== held_res) begin errors++; $display("FAIL bp_result[%0d]: got %h expected %h", k, bus.rsp_result, held_res); end
      if (bus.rsp_id !== held_id) begin errors++; $display("FAIL bp_id[%0d]: got %0d expected %0d", k, bus.rsp_id, held_id); end
    end
    rr = 1'b1;
    cycle();
    checks += 4;
    if (obs_ready !== exp_ready || exp_ready == 4'b0000) begin errors++; $display("FAIL bp_release_ready: got %b expected %b", obs_ready, exp_ready); end
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b expected 1", bus.rsp_valid); end
    if (bus.rsp_id !== m_id) begin errors++; $display("FAIL bp_release_id: got %0d expected %0d", bus.rsp_id, m_id); end
    if (bus.rsp_result !== m_res) begin errors++; $display("FAIL bp_release_result: got %h expected %h", bus.rsp_result, m_res); end
    refill(0);
  endtask

  task automatic test_arith();
    logic [3:0]  t_c [4];
    logic [31:0] t_a [4];
    logic [31:0] t_b [4];
    logic [31:0] t_r [4];
    t_c[0] = ALU_SUB;  t_a[0] = 32'd3;        t_b[0] = 32'd5;        t_r[0] = 32'hFFFF_FFFE;
    t_c[1] = ALU_SLL;  t_a[1] = 32'd1;        t_b[1] = 32'h23;       t_r[1] = 32'h8;
    t_c[2] = 4'b1111;  t_a[2] = 32'hDEAD_BEEF; t_b[2] = 32'h1234_5678; t_r[2] = 32'd0;
    t_c[3] = ALU_SRA;  t_a[3] = 32'h8000_0000; t_b[3] = 32'd4;        t_r[3] = 32'hF800_0000;
    drain();
    for (int k = 0; k < 4; k++) begin
      v = 4'b0001; c[0] = t_c[k]; a[0] = t_a[k]; b[0] = t_b[k];
      cycle();
      v = 4'b0000;
      checks += 2;
      if (obs_ctrl !== t_c[k]) begin errors++; $display("FAIL arith_ctrl[%0d]: got %h expected %h", k, obs_ctrl, t_c[k]); end
      if (bus.rsp_result !== t_r[k]) begin errors++; $display("FAIL arith_result[%0d]: got %h expected %h", k, bus.rsp_result, t_r[k]); end
    end
  endtask

  task automatic test_reset_mid();
    rr = 1'b1;
    v = 4'b0001; c[0] = ALU_ADD; a[0] = 32'd1; b[0] = 32'd2;
    cycle();
    rr = 1'b0;
    cycle();
    apply();
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.rsp_valid); end
    if (bus.rsp_result !== 32'd0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", bus.rsp_result); end
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b expected 0000", bus.req_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    v = 4'b0000;
    apply();
    @(posedge clk);
    #1;
    v = 4'b1010; new_op(1); new_op(3); rr = 1'b1;
    cycle();
    checks += 2;
    if (obs_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_grant: got %b expected 0010", obs_ready); end
    if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL rstmid_id: got %0d expected 1", bus.rsp_id); end
    refill(0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rr = ($urandom_range(0, 99) < 70);
      cycle();
      checks += 7;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", k, obs_ready, exp_ready); end
      if (obs_ctrl !== exp_ctrl) begin errors++; $display("FAIL rnd_alu_ctrl[%0d]: got %h expected %h", k, obs_ctrl, exp_ctrl); end
      if (obs_a !== exp_a) begin errors++; $display("FAIL rnd_alu_a[%0d]: got %h expected %h", k, obs_a, exp_a); end
      if (obs_b !== exp_b) begin errors++; $display("FAIL rnd_alu_b[%0d]: got %h expected %h", k, obs_b, exp_b); end
      if (bus.rsp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", k, bus.rsp_valid, m_valid); end
      if (bus.rsp_result !== m_res) begin errors++; $display("FAIL rnd_result[%0d]: got %h expected %h", k, bus.rsp_result, m_res); end
      if (bus.rsp_id !== m_id) begin errors++; $display("FAIL rnd_id[%0d]: got %0d expected %0d", k, bus.rsp_id, m_id); end
      refill(50);
    end
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    logic [15:0] want [N];
    for (int i = 0; i < N; i++) begin
      checks++;
      if (perf[16*i +: 16] !== 16'(m_cnt[i])) begin
        errors++; $display("FAIL perf_model[%0d]: got %0d expected %0d", i, perf[16*i +: 16], m_cnt[i]);
      end
    end
    drain();
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      v = 4'b0100; new_op(2); rr = 1'b1;
      cycle();
      v = 4'b0000;
    end
    cycle();
    want[0] = 16'd0; want[1] = 16'd0; want[2] = 16'd3; want[3] = 16'd0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (perf[16*i +: 16] !== want[i]) begin
        errors++; $display("FAIL perf_req2[%0d]: got %0d expected %0d", i, perf[16*i +: 16], want[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_arith();
    test_reset_mid();
    test_random();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
